// File: rtl/execute_lsu_multicycle.sv
// execute_lsu_multicycle: load/store execute unit with multi-cycle load handshake and timeout; LSU_MISALIGN_CHECK_EN adds misalignment traps
package execute_lsu_multicycle_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ROB_ID_WIDTH = 7;
  localparam int PHY_REG_ID_WIDTH = 6;
  // op encoding: [3] store, [2] unsigned, [1:0] size
  localparam logic [3:0] OP_LB = 4'b0000, OP_LH = 4'b0001, OP_LW = 4'b0010, OP_LBU = 4'b0100, OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB = 4'b1000, OP_SH = 4'b1001, OP_SW = 4'b1010;
  localparam logic [3:0] EXC_ILLEGAL_INSTRUCTION = 4'd2, EXC_LOAD_ADDRESS_MISALIGNED = 4'd4;
  localparam logic [3:0] EXC_LOAD_ACCESS_FAULT = 4'd5, EXC_STORE_ADDRESS_MISALIGNED = 4'd6;
  typedef struct packed {
    logic enable;
    logic valid;
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [ADDR_W-1:0] pc;
    logic [3:0] op;
    logic rd_enable;
    logic need_rename;
    logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
    logic [DATA_W-1:0] src2_value;
    logic [ADDR_W-1:0] lsu_addr;
    logic has_exception;
    logic [3:0] exception_id;
    logic [ADDR_W-1:0] exception_value;
  } issue_execute_pack_t;
  typedef struct packed {
    logic enable;
    logic valid;
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [ADDR_W-1:0] pc;
    logic rd_enable;
    logic need_rename;
    logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
    logic [DATA_W-1:0] rd_value;
    logic has_exception;
    logic [3:0] exception_id;
    logic [ADDR_W-1:0] exception_value;
  } execute_wb_pack_t;
  typedef struct packed {
    logic enable;
    logic [PHY_REG_ID_WIDTH-1:0] phy_id;
    logic [DATA_W-1:0] value;
  } execute_feedback_channel_t;
  typedef struct packed {
    logic enable;
    logic flush;
  } commit_feedback_pack_t;
endpackage

module execute_lsu_multicycle
  import execute_lsu_multicycle_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  issue_execute_pack_t           issue_lsu_fifo_data_out,
  input  logic                          issue_lsu_fifo_data_out_valid,
  output logic                          issue_lsu_fifo_pop,
  output logic                          exlsu_stbuf_read_req,
  output logic [ADDR_WIDTH-1:0]         exlsu_stbuf_read_addr,
  output logic [1:0]                    exlsu_stbuf_read_size,
  input  logic                          stbuf_exlsu_read_ack,
  input  logic [DATA_WIDTH-1:0]         stbuf_exlsu_read_data,
  output logic [ROB_ID_WIDTH-1:0]       exlsu_stbuf_rob_id,
  output logic [ADDR_WIDTH-1:0]         exlsu_stbuf_write_addr,
  output logic [1:0]                    exlsu_stbuf_write_size,
  output logic [DATA_WIDTH-1:0]         exlsu_stbuf_write_data,
  output logic                          exlsu_stbuf_push,
  input  logic                          stbuf_exlsu_full,
  output execute_wb_pack_t              lsu_wb_port_data_in,
  output logic                          lsu_wb_port_we,
  output logic                          lsu_wb_port_flush,
  output execute_feedback_channel_t     lsu_execute_channel_feedback_pack,
  input  commit_feedback_pack_t         commit_feedback_pack
);
  localparam int LW = $clog2(DATA_WIDTH / 8);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic {IDLE, LOAD_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  execute_wb_pack_t wb_q, wb_d;
  execute_feedback_channel_t fb_q, fb_d;
  logic we_q, we_d, wbf_q, wbf_d;
  issue_execute_pack_t p;
  logic flush, store, uns, done, exc, fb_en;
  logic [1:0] size;
  logic [3:0] exc_id;
  logic [ADDR_WIDTH-1:0] exc_val;
  logic [DATA_WIDTH-1:0] lane, ld_val, rd_val;
`ifdef LSU_MISALIGN_CHECK_EN
  logic mis;
  assign mis = (size == 2'b01 && p.lsu_addr[0]) || (size == 2'b10 && p.lsu_addr[1:0] != 2'b00);
`endif
  assign p = issue_lsu_fifo_data_out;
  assign flush = commit_feedback_pack.enable & commit_feedback_pack.flush;
  assign store = p.op[3];
  assign uns = p.op[2];
  assign size = p.op[1:0];
  assign lane = stbuf_exlsu_read_data >> {p.lsu_addr[LW-1:0], 3'b000};
  assign ld_val = size == 2'b00 ? (uns ? DATA_WIDTH'(lane[7:0]) : DATA_WIDTH'($signed(lane[7:0]))) :
                  size == 2'b01 ? (uns ? DATA_WIDTH'(lane[15:0]) : DATA_WIDTH'($signed(lane[15:0]))) :
                  DATA_WIDTH'($signed(lane[31:0]));
  assign exlsu_stbuf_read_addr = {p.lsu_addr[ADDR_WIDTH-1:LW], {LW{1'b0}}};
  assign exlsu_stbuf_read_size = size;
  assign exlsu_stbuf_rob_id = p.rob_id;
  assign exlsu_stbuf_write_addr = p.lsu_addr;
  assign exlsu_stbuf_write_size = size;
  assign exlsu_stbuf_write_data = size == 2'b00 ? DATA_WIDTH'(p.src2_value[7:0]) :
                                  size == 2'b01 ? DATA_WIDTH'(p.src2_value[15:0]) : DATA_WIDTH'(p.src2_value[31:0]);
  assign issue_lsu_fifo_pop = done;
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    done = 1'b0;
    exlsu_stbuf_push = 1'b0;
    exlsu_stbuf_read_req = 1'b0;
    fb_en = 1'b0;
    exc = p.has_exception;
    exc_id = p.exception_id;
    exc_val = p.exception_value;
    rd_val = '0;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (issue_lsu_fifo_data_out_valid && p.enable) begin
        if (!p.valid || p.has_exception) begin
          done = 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
        end else if (mis) begin
          done = 1'b1;
          exc = 1'b1;
          exc_id = store ? EXC_STORE_ADDRESS_MISALIGNED : EXC_LOAD_ADDRESS_MISALIGNED;
          exc_val = p.lsu_addr;
`endif
        end else if (store) begin
          exlsu_stbuf_push = !stbuf_exlsu_full;
          done = !stbuf_exlsu_full;
        end else begin
          state_d = LOAD_WAIT;
        end
      end
    end else begin
      exlsu_stbuf_read_req = 1'b1;
      if (stbuf_exlsu_read_ack) begin
        done = 1'b1;
        state_d = IDLE;
        rd_val = ld_val;
        fb_en = p.rd_enable & p.need_rename;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        done = 1'b1;
        state_d = IDLE;
        exc = 1'b1;
        exc_id = EXC_LOAD_ACCESS_FAULT;
        exc_val = p.lsu_addr;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  always_comb begin
    wb_d = '0;
    if (done) wb_d = '{1'b1, p.valid, p.rob_id, p.pc, p.rd_enable, p.need_rename, p.rd_phy, rd_val, exc, exc_id, exc_val};
    fb_d = fb_en ? '{1'b1, p.rd_phy, rd_val} : '0;
    we_d = done;
    wbf_d = !done;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wb_q <= '0;
      fb_q <= '0;
      we_q <= 1'b0;
      wbf_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wb_q <= wb_d;
      fb_q <= fb_d;
      we_q <= we_d;
      wbf_q <= wbf_d;
    end
  end
  assign lsu_wb_port_data_in = wb_q;
  assign lsu_wb_port_we = we_q;
  assign lsu_wb_port_flush = wbf_q;
  assign lsu_execute_channel_feedback_pack = fb_q;
endmodule

// File: doc/execute_lsu_multicycle.md
Name: execute_lsu_multicycle

Overview:
- Next-generation load/store execute unit for the out-of-order core. Sits between the issue->LSU FIFO and the LSU writeback port.
- Extends the single-cycle LSU with a multi-cycle load handshake to the store buffer / bus, including a wait timeout and access-fault reporting.
- Adds sized load extraction with sign/zero extension and parametrised address/data widths.
- Stores are pushed into the store buffer; loads block the unit until acknowledged or timed out.

Parameters:
ADDR_WIDTH, 32, address width of lsu_addr and bus addresses
DATA_WIDTH, 32, bus/register data width (32 or 64; lw extraction uses 32-bit lanes)
TIMEOUT_CYCLES, 16, max cycles in LOAD_WAIT before load_access_fault (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
issue_lsu_fifo_data_out  in  issue_execute_pack_t  head of issue->LSU FIFO
issue_lsu_fifo_data_out_valid  in  1  FIFO non-empty
issue_lsu_fifo_pop  out  1  consume FIFO head this cycle
exlsu_stbuf_read_req  out  1  load request, held high in LOAD_WAIT
exlsu_stbuf_read_addr  out  ADDR_WIDTH  load address, aligned down to DATA_WIDTH/8
exlsu_stbuf_read_size  out  2  00 byte, 01 half, 10 word
stbuf_exlsu_read_ack  in  1  load data valid this cycle
stbuf_exlsu_read_data  in  DATA_WIDTH  aligned load word
exlsu_stbuf_rob_id  out  ROB_ID_WIDTH  store rob id
exlsu_stbuf_write_addr  out  ADDR_WIDTH  store address
exlsu_stbuf_write_size  out  2  store size
exlsu_stbuf_write_data  out  DATA_WIDTH  store data, zero-extended low bytes of src2_value
exlsu_stbuf_push  out  1  store push
stbuf_exlsu_full  in  1  store buffer full
lsu_wb_port_data_in  out  execute_wb_pack_t  writeback pack (registered)
lsu_wb_port_we  out  1  writeback write enable (registered)
lsu_wb_port_flush  out  1  writeback register clear (registered)
lsu_execute_channel_feedback_pack  out  execute_feedback_channel_t  bypass/wakeup (registered)
commit_feedback_pack  in  commit_feedback_pack_t  flush = enable & flush

Behaviour:
- Reset values: state IDLE, wait counter 0, wb_data.enable=0, we=0, flush=1, feedback.enable=0.
- Combinational outputs are 0 in reset: pop, push, read_req.
- Completion cycle C: pop=1 in C. Registered outputs take effect in C+1 with we=1, flush=0, enable=1, and valid/rob_id/pc/rd fields copied from the pack.
- Idle cycle (no completion): we=0, flush=1, feedback.enable=0 next cycle.
- IDLE, head valid, no flush:
  - !enable: no action.
  - !valid or has_exception: complete immediately; exception fields pass through.
  - Store: if !full, push=1 with rob_id, lsu_addr, size, src2 bytes; complete same cycle. If full, push=0, pop=0, stall.
  - Load: go to LOAD_WAIT next cycle. read_req asserts from LOAD_WAIT entry.
- LOAD_WAIT:
  - read_req=1 with addr/size stable; counter increments each cycle.
  - ack: complete in that cycle; return to IDLE.
  - Load extraction: lane = lsu_addr low bits. lb/lh sign-extend; lbu/lhu zero-extend; lw sign-extends to DATA_WIDTH.
  - counter==TIMEOUT_CYCLES-1 without ack: complete with has_exception=1, exception_id=load_access_fault, exception_value=lsu_addr; go to IDLE.
- Feedback: enable=1 only for loads completing without exception with rd_enable & need_rename. phy_id=rd_phy, value=rd_value, same cycle as wb.
- Flush (commit enable & flush), any state:
  - pop=0, push=0, read_req=0 that cycle; state IDLE, counter 0.
  - Next cycle: we=0, flush=1, feedback.enable=0.
  - Flush wins over simultaneous ack or store push.
- Late ack arriving in IDLE is ignored.
- Reset mid-load drops read_req asynchronously.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: in IDLE, a misaligned access completes immediately, with no bus or store-buffer activity and exception_value=lsu_addr.
  - Misaligned means half with addr[0]!=0, or word with addr[1:0]!=0.
  - Exception id: load_address_misaligned (loads) or store_address_misaligned (stores).
- Undefined: no check; misaligned accesses are issued with the aligned address and a lane select.

Test Plan:
- Reset, then idle with valid=0 -> next cycle we=0, flush=1, pop=0, feedback.enable=0.
- Head has_exception=1, illegal_instruction -> pop=1 same cycle; next cycle we=1, has_exception=1, exception_id=illegal_instruction.
- sh, rob_id=7, addr=0xaaccbeef, src2=0xdeadbeef, full=1 for 1 cycle -> pop=0, push=0; then push=1, size=01, data=0xbeef, addr=0xaaccbeef, pop=1.
- lb, addr=0x1003, rd_phy=10, rd_enable/need_rename=1, ack 3 cycles after req with data=0x80ffffff -> rd_value=0xffffff80, feedback phy_id=10 value=0xffffff80; lbu -> 0x80.
- Load with no ack, TIMEOUT_CYCLES=16 -> completion on 16th LOAD_WAIT cycle with load_access_fault, exception_value=addr, feedback.enable=0.
- Flush asserted in same cycle as ack -> pop=0; next cycle we=0, flush=1; read_req low; next load starts with counter 0.
